fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream drain stage for the byte-output FIFO: pops one byte whenever the FIFO is non-empty
//  and serializes it onto a UART line (start, 8 data LSB-first, optional parity, stop).
//  Sits between fifo.data_out/empty_flag/en_r and the chip TX pin; the only FIFO reader.
// PARAMETERS
//  CLK_DIV     16  clk cycles per UART bit (>=2)
//  PARITY_EN   0   1 = insert parity bit after data
//  PARITY_ODD  0   1 = odd parity, 0 = even (ignored if PARITY_EN=0)
//  STOP_BITS   1   number of stop bits (1 or 2)
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  rst         in   1  synchronous, active-high reset
//  tx_en       in   1  1 = allowed to start new frames
//  empty_flag  in   1  FIFO empty indicator
//  fifo_data   in   8  FIFO data_out; valid the cycle after an en_r pulse
//  en_r        out  1  FIFO read enable, single-cycle pulse per byte
//  tx          out  1  serial line, idle high
//  busy        out  1  1 whenever state != IDLE
//  frame_done  out  1  1-cycle pulse after last stop bit
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE, tx=1, en_r=0, busy=0, frame_done=0, shift reg=0, counters=0.
//  States: IDLE -> FETCH -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE|FETCH.
//  IDLE: on edge N with tx_en=1 && empty_flag=0 -> FETCH. Otherwise stay, tx=1.
//  FETCH: en_r=1 for exactly this cycle (edge N..N+1) -> LOAD. Never more than one pulse per byte.
//  LOAD: at edge N+2 capture fifo_data into shift reg, compute parity (^data, inverted if PARITY_ODD),
//    tx<=0, enter START.
//  Bit timing: baud counter 0..CLK_DIV-1 restarts on every state entry; bit_tick at count CLK_DIV-1.
//  START: tx=0 for CLK_DIV cycles. DATA: bit_cnt 0..7, tx=shift[0], shift right on each bit_tick.
//  PARITY (PARITY_EN=1 only): tx=parity for CLK_DIV cycles.
//  STOP: tx=1 for STOP_BITS*CLK_DIV cycles; on final tick frame_done=1 for one cycle, then
//    if tx_en && !empty_flag -> FETCH (back-to-back, 2 idle-high cycles between frames) else IDLE.
//  Frame length START..end of STOP = (9+PARITY_EN+STOP_BITS)*CLK_DIV cycles.
//  tx is registered; no combinational path from inputs to tx.
//  tx_en deasserted mid-frame: current frame completes, no new fetch.
//  empty_flag rising mid-frame: ignored; only sampled in IDLE and at end of STOP.
//  en_r never asserted while empty_flag=1 at its decision edge (no FIFO underflow).
//  rst mid-frame: abort at next edge, tx=1 immediately, byte lost, no en_r issued.
// STRUCTURE
//  Shared include fifo_uart_defs.vh: state encodings (3-bit localparams), parity helper function.
//  One sub-module: uart_baud_tick (counter, inputs clk/rst/restart, output bit_tick, param CLK_DIV).
//  Top: FSM, bit counter (3 bits), stop counter, shift register, output registers.
// TESTING
//  1. Reset held 3 cycles, empty_flag=1 -> tx=1, en_r=0, busy=0 throughout; after release still idle.
//  2. Single byte 8'hA5, CLK_DIV=16, no parity -> en_r one pulse; tx = 0,1,0,1,0,0,1,0,1,1 each 16 clks;
//     frame_done pulse 160 cycles after tx falls.
//  3. Drive FIFO with 32'h03020100 written then drained -> bytes 00,01,02,03 sent back-to-back,
//     exactly 4 en_r pulses, 2 idle-high cycles between frames, busy stays 1 until last stop.
//  4. PARITY_EN=1, PARITY_ODD=1, byte 8'h07 -> parity bit=0; PARITY_ODD=0 -> parity bit=1; STOP_BITS=2
//     -> stop high 32 cycles.
//  5. tx_en dropped during DATA of byte 8'h3C -> frame completes, no further en_r while FIFO non-empty.
//  6. rst asserted mid-DATA -> tx=1 next edge, busy=0, no en_r; after release next byte sent intact.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
//   state_t    : FSM state encoding (3 bits)
//   parity_bit : parity of a data byte, even or odd sense
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  // Even parity is the plain XOR reduction; odd parity inverts it.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer for the UART transmitter.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   restart  : clear the counter (asserted on every FSM state change)
//   bit_tick : high on the last clock of each bit period (count == CLK_DIV-1)
module uart_baud_tick #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign bit_tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || restart) cnt <= '0;
    else if (bit_tick)  cnt <= '0;
    else                cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte at a time from the upstream FIFO and
// serializes it as a UART frame (start, 8 data LSB-first, optional parity,
// 1 or 2 stop bits).
//   clk        : system clock
//   rst        : synchronous active-high reset
//   tx_en      : permission to start new frames
//   empty_flag : FIFO empty indicator
//   fifo_data  : FIFO read data, valid the cycle after an en_r pulse
//   en_r       : FIFO read enable, one pulse per byte
//   tx         : registered serial line, idle high
//   busy       : high whenever the FSM is not idle
//   frame_done : one-cycle pulse after the last stop bit
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       empty_flag,
  input  logic [7:0] fifo_data,
  output logic       en_r,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic STOP_LAST = (STOP_BITS == 2);
  localparam logic ODD       = (PARITY_ODD != 0);
  localparam logic HAS_PAR   = (PARITY_EN != 0);

  state_t     state, next_state;
  logic       bit_tick, restart;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic       stop_cnt, stop_cnt_d;
  logic [7:0] shift, shift_d;
  logic       par, par_d;
  logic       tx_d;
  logic       can_fetch, last_stop;

  // The empty flag and tx_en are only acted on in IDLE and at the final
  // stop tick; everywhere else they are ignored.
  assign can_fetch = tx_en && !empty_flag;
  assign last_stop = (state == ST_STOP) && bit_tick && (stop_cnt == STOP_LAST);

  // Bit timing restarts on every state entry so each state owns whole periods.
  assign restart = (next_state != state);

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .bit_tick (bit_tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (can_fetch) next_state = ST_FETCH;
      ST_FETCH:  next_state = ST_LOAD;
      ST_LOAD:   next_state = ST_START;
      ST_START:  if (bit_tick) next_state = ST_DATA;
      ST_DATA:   if (bit_tick && bit_cnt == 3'd7)
                   next_state = HAS_PAR ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_tick) next_state = ST_STOP;
      ST_STOP:   if (last_stop) next_state = can_fetch ? ST_FETCH : ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    en_r = (state == ST_FETCH);
    busy = (state != ST_IDLE);
  end

  // Datapath next values. The line level is derived from the state being
  // entered so that tx is a pure register with no input-to-pin path.
  always_comb begin
    shift_d    = shift;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    par_d      = par;
    case (state)
      ST_LOAD: begin
        shift_d    = fifo_data;
        par_d      = parity_bit(fifo_data, ODD);
        bit_cnt_d  = 3'd0;
        stop_cnt_d = 1'b0;
      end
      ST_DATA: if (bit_tick) begin
        shift_d   = {1'b0, shift[7:1]};
        bit_cnt_d = bit_cnt + 3'd1;
      end
      ST_STOP: if (bit_tick) stop_cnt_d = stop_cnt + 1'b1;
      default: ;
    endcase

    case (next_state)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shift      <= 8'd0;
      bit_cnt    <= 3'd0;
      stop_cnt   <= 1'b0;
      par        <= 1'b0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      shift      <= shift_d;
      bit_cnt    <= bit_cnt_d;
      stop_cnt   <= stop_cnt_d;
      par        <= par_d;
      tx         <= tx_d;
      frame_done <= last_stop;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: three transmitter configurations fed from FIFO models.
// Pushed bytes go to an expected-byte scoreboard; a line monitor per channel
// decodes each frame cycle by cycle and compares against the scoreboard.
module tb_fifo_uart_tx;

  localparam int NCH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_w   [NCH];
  logic       tx_en_w [NCH];
  logic       empty_w [NCH];
  logic [7:0] fdata_w [NCH];
  logic       en_r_w  [NCH];
  logic       tx_w    [NCH];
  logic       busy_w  [NCH];
  logic       fd_w    [NCH];

  fifo_uart_tx #(.CLK_DIV(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_ch0 (
    .clk(clk), .rst(rst_w[0]), .tx_en(tx_en_w[0]), .empty_flag(empty_w[0]),
    .fifo_data(fdata_w[0]), .en_r(en_r_w[0]), .tx(tx_w[0]), .busy(busy_w[0]),
    .frame_done(fd_w[0]));
  fifo_uart_tx #(.CLK_DIV(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_ch1 (
    .clk(clk), .rst(rst_w[1]), .tx_en(tx_en_w[1]), .empty_flag(empty_w[1]),
    .fifo_data(fdata_w[1]), .en_r(en_r_w[1]), .tx(tx_w[1]), .busy(busy_w[1]),
    .frame_done(fd_w[1]));
  fifo_uart_tx #(.CLK_DIV(3), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_ch2 (
    .clk(clk), .rst(rst_w[2]), .tx_en(tx_en_w[2]), .empty_flag(empty_w[2]),
    .fifo_data(fdata_w[2]), .en_r(en_r_w[2]), .tx(tx_w[2]), .busy(busy_w[2]),
    .frame_done(fd_w[2]));

  function automatic int p_div(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 5 : 3);
  endfunction
  function automatic int p_par(input int k);
    return (k == 0) ? 0 : 1;
  endfunction
  function automatic int p_odd(input int k);
    return (k == 1) ? 1 : 0;
  endfunction
  function automatic int p_stop(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int k, input bit ok, input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s ch%0d: got %0h, expected %0h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  // FIFO models: read data appears the cycle after en_r.
  logic [7:0] fmem [NCH][256];
  int wp [NCH] = '{default: 0};
  int rp [NCH] = '{default: 0};

  always_comb
    for (int k = 0; k < NCH; k++) empty_w[k] = (wp[k] == rp[k]);

  initial for (int k = 0; k < NCH; k++) fdata_w[k] = 8'h00;

  always @(posedge clk)
    for (int k = 0; k < NCH; k++)
      if (en_r_w[k] === 1'b1 && wp[k] != rp[k]) begin
        fdata_w[k] <= fmem[k][rp[k] & 255];
        rp[k]      <= rp[k] + 1;
      end

  // Scoreboard of bytes expected on each line, in push order.
  logic [7:0] exp_mem [NCH][256];
  int exp_wp [NCH] = '{default: 0};
  int exp_rp [NCH] = '{default: 0};

  task automatic push(input int k, input logic [7:0] b);
    fmem[k][wp[k] & 255]       = b;
    wp[k]                      = wp[k] + 1;
    exp_mem[k][exp_wp[k] & 255] = b;
    exp_wp[k]                  = exp_wp[k] + 1;
  endtask

  // Read-enable bookkeeping
  int  en_cnt    [NCH] = '{default: 0};
  int  under_err [NCH] = '{default: 0};
  int  dbl_err   [NCH] = '{default: 0};
  int  fd_cnt    [NCH] = '{default: 0};
  int  frames    [NCH] = '{default: 0};
  logic en_prev  [NCH] = '{default: 1'b0};

  always @(negedge clk)
    for (int k = 0; k < NCH; k++) begin
      if (en_r_w[k] === 1'b1) begin
        en_cnt[k] = en_cnt[k] + 1;
        if (empty_w[k]) under_err[k] = under_err[k] + 1;
        if (en_prev[k]) dbl_err[k] = dbl_err[k] + 1;
      end
      en_prev[k] = en_r_w[k];
      if (fd_w[k] === 1'b1) fd_cnt[k] = fd_cnt[k] + 1;
    end

  // Line monitor: a frame starts on the first low sample outside reset.
  task automatic monitor(input int k);
    int div, np, nb, len, bact;
    logic eb [12];
    logic [7:0] b;
    bit have, ab, go, bad, bb;
    logic g1;
    div = p_div(k);
    np  = p_par(k);
    nb  = 9 + np + p_stop(k);
    len = nb * div;
    have = 0;
    forever begin
      if (!have) @(negedge clk);
      have = 0;
      if (rst_w[k] !== 1'b0 || tx_w[k] !== 1'b0) continue;
      if (exp_rp[k] == exp_wp[k]) begin
        chk("unexpected_frame", k, 1'b0, 1, 0);
        b = 8'h00;
      end else begin
        b = exp_mem[k][exp_rp[k] & 255];
        exp_rp[k] = exp_rp[k] + 1;
      end
      for (int i = 0; i < 12; i++) eb[i] = 1'b1;
      eb[0] = 1'b0;
      for (int i = 0; i < 8; i++) eb[i+1] = b[i];
      if (np != 0) eb[9] = (^b) ^ (p_odd(k) != 0);
      ab = 0; go = 0; bad = 0; bb = 0; bact = 0;
      for (int j = 0; j < len; j++) begin
        if (j > 0) @(negedge clk);
        if (rst_w[k] === 1'b1) begin ab = 1; break; end
        if (j % div == 0) bb = 0;
        if (tx_w[k] !== eb[j/div] && !bb) begin bb = 1; bact = int'(tx_w[k]); end
        if (busy_w[k] !== 1'b1 || fd_w[k] !== 1'b0) bad = 1;
        if (j % div == div - 1)
          chk($sformatf("frame_bit%0d_byte%02h", j/div, b), k, !bb,
              bb ? bact : int'(eb[j/div]), int'(eb[j/div]));
        if (j == len - 1) go = tx_en_w[k] && !empty_w[k];
      end
      if (ab) begin
        @(negedge clk);
        chk("rst_abort", k, tx_w[k] === 1'b1 && busy_w[k] === 1'b0 && en_r_w[k] === 1'b0,
            {tx_w[k], busy_w[k], en_r_w[k]}, 3'b100);
        continue;
      end
      chk("busy_in_frame", k, !bad, bad, 0);
      @(negedge clk);
      chk("frame_done", k, fd_w[k] === 1'b1 && busy_w[k] === go, {fd_w[k], busy_w[k]}, {1'b1, go});
      frames[k] = frames[k] + 1;
      if (go) begin
        @(negedge clk);
        g1 = tx_w[k];
        @(negedge clk);
        chk("b2b_gap", k, g1 === 1'b1 && tx_w[k] === 1'b0 && busy_w[k] === 1'b1,
            {g1, tx_w[k], busy_w[k]}, 3'b101);
        have = 1;
      end
    end
  endtask

  initial fork
    monitor(0);
    monitor(1);
    monitor(2);
  join_none

  task automatic wait_idle(input int limit);
    int c;
    bit done;
    c = 0; done = 0;
    while (!done && c < limit) begin
      @(negedge clk);
      c++;
      done = 1;
      for (int k = 0; k < NCH; k++)
        if (wp[k] != rp[k] || busy_w[k] !== 1'b0 || exp_rp[k] != exp_wp[k]) done = 0;
    end
    chk("drain_in_time", -1, done, c, limit);
  endtask

  task automatic wait_fall(input int k, input int limit);
    int c;
    c = 0;
    while (tx_w[k] !== 1'b0 && c < limit) begin
      @(negedge clk);
      c++;
    end
    chk("tx_falls", k, tx_w[k] === 1'b0, tx_w[k], 0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad_rst [NCH];
    int snap;
    for (int k = 0; k < NCH; k++) begin
      rst_w[k] = 1'b1; tx_en_w[k] = 1'b1; bad_rst[k] = 0;
    end

    // Reset held 3 cycles with the FIFOs empty, then stays idle afterwards.
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < NCH; k++)
        if (tx_w[k] !== 1'b1 || en_r_w[k] !== 1'b0 || busy_w[k] !== 1'b0 || fd_w[k] !== 1'b0)
          bad_rst[k] = 1;
    end
    for (int k = 0; k < NCH; k++) chk("reset_outputs", k, !bad_rst[k], bad_rst[k], 0);
    step(1);
    for (int k = 0; k < NCH; k++) begin rst_w[k] = 1'b0; bad_rst[k] = 0; end
    repeat (5) begin
      @(negedge clk);
      for (int k = 0; k < NCH; k++)
        if (tx_w[k] !== 1'b1 || en_r_w[k] !== 1'b0 || busy_w[k] !== 1'b0) bad_rst[k] = 1;
    end
    for (int k = 0; k < NCH; k++) chk("idle_after_reset", k, !bad_rst[k], bad_rst[k], 0);

    // Single byte, then the parity byte, then a back-to-back burst.
    step(1);
    for (int k = 0; k < NCH; k++) push(k, 8'hA5);
    wait_idle(2000);
    step(1);
    for (int k = 0; k < NCH; k++) push(k, 8'h07);
    wait_idle(2000);
    step(1);
    for (int k = 0; k < NCH; k++)
      for (int i = 0; i < 4; i++) push(k, 8'(i));
    wait_idle(4000);

    // tx_en dropped mid-DATA: frame completes, nothing else fetched.
    step(1);
    push(0, 8'h3C); push(0, 8'h11); push(0, 8'h22);
    wait_fall(0, 100);
    step(3 * 16);
    tx_en_w[0] = 1'b0;
    step(200);
    snap = en_cnt[0];
    step(60);
    chk("no_fetch_when_disabled", 0, en_cnt[0] == snap && busy_w[0] === 1'b0, en_cnt[0] - snap, 0);
    chk("fifo_left_intact", 0, (wp[0] - rp[0]) == 2, wp[0] - rp[0], 2);
    tx_en_w[0] = 1'b1;
    wait_idle(2000);

    // Reset mid-DATA: in-flight byte lost, next byte sent intact.
    step(1);
    push(0, 8'h55); push(0, 8'h9A);
    exp_rp[0] = exp_rp[0];
    wait_fall(0, 100);
    step(4 * 16);
    rst_w[0] = 1'b1;
    step(1);
    rst_w[0] = 1'b0;
    wait_idle(2000);

    // Randomized traffic with tx_en wobble.
    for (int it = 0; it < 30; it++) begin
      step(1);
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          int n;
          n = $urandom_range(1, 3);
          for (int i = 0; i < n; i++) push(k, 8'($urandom));
        end
        tx_en_w[k] = ($urandom_range(0, 7) != 0);
      end
      step($urandom_range(0, 150));
    end
    step(1);
    for (int k = 0; k < NCH; k++) tx_en_w[k] = 1'b1;
    wait_idle(30000);
    step(5);

    for (int k = 0; k < NCH; k++) begin
      chk("scoreboard_empty", k, exp_rp[k] == exp_wp[k], exp_wp[k] - exp_rp[k], 0);
      chk("en_r_per_byte", k, en_cnt[k] == wp[k], en_cnt[k], wp[k]);
      chk("frame_done_count", k, fd_cnt[k] == frames[k], fd_cnt[k], frames[k]);
      chk("no_underflow", k, under_err[k] == 0, under_err[k], 0);
      chk("single_pulse_en_r", k, dbl_err[k] == 0, dbl_err[k], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
